// File: rtl/b2_demux_1_4_seq_if.sv
// Bundles the write-side inputs and lane-side outputs of the 1:4 demux.
// No added latency; this file holds only wiring.
// No backpressure; the producer may write on every cycle.
interface b2_demux_1_4_seq_if #(
    parameter int W = 2
);
    // Write side: clear, routing control and data word
    logic           clr;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   d;
    logic           in_valid;

    // Lane side: registered lanes, strobes and frame view
    logic [W-1:0]   y0;
    logic [W-1:0]   y1;
    logic [W-1:0]   y2;
    logic [W-1:0]   y3;
    logic [3:0]     y_strobe;
    logic [1:0]     ptr;
    logic           frame_valid;
    logic [4*W-1:0] frame;

    // Producer drives the write side and observes the lanes
    modport master (
        output clr, mode, sel, d, in_valid,
        input  y0, y1, y2, y3, y_strobe, ptr, frame_valid, frame
    );

    // Demux consumes the write side and drives the lanes
    modport slave (
        input  clr, mode, sel, d, in_valid,
        output y0, y1, y2, y3, y_strobe, ptr, frame_valid, frame
    );
endinterface

// File: rtl/b2_demux_1_4_seq.sv
// Routes a W-bit word to one of four registered lanes, either by sel or round-robin.
// One cycle: a write sampled at an edge appears on the lane, strobe and frame_valid after it.
// No backpressure; a write is accepted on every edge where in_valid is high.
module b2_demux_1_4_seq #(
    parameter int W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    b2_demux_1_4_seq_if.slave    bus
);

    logic [W-1:0] lane_q [4];
    logic [W-1:0] lane_d [4];
    logic [1:0]   ptr_q;
    logic [1:0]   ptr_d;
    logic [3:0]   strobe_q;
    logic [3:0]   strobe_d;
    logic         frame_valid_q;
    logic         frame_valid_d;
    logic [1:0]   wr_idx;

    // Destination lane: the auto pointer in round-robin mode, sel otherwise.
    // ptr is already 0 on the first auto edge because every addressed cycle zeroes it.
    always_comb begin
        wr_idx = bus.mode ? ptr_q : bus.sel;
    end

    // Next-state: clear beats write; addressed cycles drop any partial auto frame
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = lane_q[i];
        end
        ptr_d         = bus.mode ? ptr_q : 2'd0;
        strobe_d      = 4'b0000;
        frame_valid_d = 1'b0;

        if (bus.clr) begin
            for (int i = 0; i < 4; i++) begin
                lane_d[i] = '0;
            end
            ptr_d = 2'd0;
        end else if (bus.in_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_idx == i[1:0]) begin
                    lane_d[i] = bus.d;
                end
            end
            strobe_d = 4'b0001 << wr_idx;
            if (bus.mode) begin
                ptr_d         = ptr_q + 2'd1;
                frame_valid_d = (ptr_q == 2'd3);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
            ptr_q         <= 2'd0;
            strobe_q      <= 4'b0000;
            frame_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= lane_d[i];
            end
            ptr_q         <= ptr_d;
            strobe_q      <= strobe_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Outputs come straight from registers; no combinational path from the inputs
    assign bus.y0          = lane_q[0];
    assign bus.y1          = lane_q[1];
    assign bus.y2          = lane_q[2];
    assign bus.y3          = lane_q[3];
    assign bus.y_strobe    = strobe_q;
    assign bus.ptr         = ptr_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame       = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};

endmodule

// File: tb/tb_b2_demux_1_4_seq.sv
// Directed plus random stimulus against a behavioural reference with a scoreboard queue.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The design has no backpressure, so every step produces exactly one expected entry.
module tb_b2_demux_1_4_seq;
    localparam int W = 2;

    typedef struct packed {
        logic [4*W-1:0] frame;
        logic [3:0]     strb;
        logic [1:0]     ptr;
        logic           fv;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fail;
    exp_t sb_q [$];

    // Reference state
    logic [W-1:0] m_lane [4];
    logic [1:0]   m_ptr;
    logic [3:0]   m_strb;
    logic         m_fv;

    b2_demux_1_4_seq_if #(.W(W)) bus ();

    b2_demux_1_4_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = '0;
        m_ptr  = 2'd0;
        m_strb = 4'b0000;
        m_fv   = 1'b0;
    endtask

    // Behavioural reference of one edge, written from the lane-routing rules
    task automatic model_edge(input logic clr, input logic mode, input logic [1:0] sel,
                              input logic [W-1:0] d, input logic vld);
        int lane;
        m_strb = 4'b0000;
        m_fv   = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            lane = mode ? int'(m_ptr) : int'(sel);
            if (vld) begin
                m_lane[lane] = d;
                m_strb[lane] = 1'b1;
                if (mode) begin
                    m_fv  = (m_ptr == 2'd3);
                    m_ptr = m_ptr + 2'd1;
                end
            end
            if (!mode) m_ptr = 2'd0;
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.frame = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        e.strb  = m_strb;
        e.ptr   = m_ptr;
        e.fv    = m_fv;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_frame"}, 32'(bus.frame), 32'(e.frame));
        chk({tag, "_strobe"}, 32'(bus.y_strobe), 32'(e.strb));
        chk({tag, "_ptr"}, 32'(bus.ptr), 32'(e.ptr));
        chk({tag, "_fv"}, 32'(bus.frame_valid), 32'(e.fv));
    endtask

    // One clock of stimulus: drive, predict, clock, compare
    task automatic step(input string tag, input logic clr, input logic mode,
                        input logic [1:0] sel, input logic [W-1:0] d, input logic vld);
        @(negedge clk);
        bus.clr      = clr;
        bus.mode     = mode;
        bus.sel      = sel;
        bus.d        = d;
        bus.in_valid = vld;
        model_edge(clr, mode, sel, d, vld);
        sb_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic idle(input string tag, input logic mode);
        step(tag, 1'b0, mode, 2'd0, 2'b00, 1'b0);
    endtask

    initial begin
        logic [W-1:0] words [4];
        n_asserts = 0;
        n_fail    = 0;
        words[0] = 2'b01; words[1] = 2'b10; words[2] = 2'b11; words[3] = 2'b00;

        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.mode     = 1'b0;
        bus.sel      = 2'd0;
        bus.d        = '0;
        bus.in_valid = 1'b0;
        model_reset();
        #12;
        chk("reset_frame", 32'(bus.frame), 32'd0);
        chk("reset_strobe", 32'(bus.y_strobe), 32'd0);
        chk("reset_ptr", 32'(bus.ptr), 32'd0);
        chk("reset_fv", 32'(bus.frame_valid), 32'd0);
        rst_n = 1'b1;

        // Addressed write to lane 2
        step("addr_sel2", 1'b0, 1'b0, 2'd2, 2'b11, 1'b1);
        chk("addr_y2", 32'(bus.y2), 32'd3);
        chk("addr_strobe", 32'(bus.y_strobe), 32'b0100);
        chk("addr_others", 32'({bus.y3, bus.y1, bus.y0}), 32'd0);
        idle("addr_idle", 1'b0);
        chk("addr_idle_strobe", 32'(bus.y_strobe), 32'd0);

        // Overwrite the same lane; last write wins
        step("ovw_a", 1'b0, 1'b0, 2'd1, 2'b01, 1'b1);
        step("ovw_b", 1'b0, 1'b0, 2'd1, 2'b10, 1'b1);
        chk("ovw_y1", 32'(bus.y1), 32'd2);

        // Back-to-back auto frame
        for (int i = 0; i < 4; i++) begin
            step("auto_b2b", 1'b0, 1'b1, 2'd3, words[i], 1'b1);
            chk("auto_ptr", 32'(bus.ptr), 32'((i + 1) % 4));
            chk("auto_strobe", 32'(bus.y_strobe), 32'(4'b0001 << i));
        end
        chk("auto_fv", 32'(bus.frame_valid), 32'd1);
        chk("auto_frame", 32'(bus.frame), 32'b00_11_10_01);
        idle("auto_idle", 1'b1);
        chk("auto_fv_pulse", 32'(bus.frame_valid), 32'd0);

        // Gapped auto frame
        step("gap_clr", 1'b1, 1'b1, 2'd0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("gap_wr", 1'b0, 1'b1, 2'd0, words[i], 1'b1);
            if (i < 3) begin
                idle("gap_idle", 1'b1);
                chk("gap_strobe0", 32'(bus.y_strobe), 32'd0);
                idle("gap_idle", 1'b1);
            end
        end
        chk("gap_fv", 32'(bus.frame_valid), 32'd1);
        chk("gap_frame", 32'(bus.frame), 32'b00_11_10_01);

        // Mode abort discards a partial frame
        step("abort_w0", 1'b0, 1'b1, 2'd0, 2'b01, 1'b1);
        step("abort_w1", 1'b0, 1'b1, 2'd0, 2'b10, 1'b1);
        idle("abort_m0", 1'b0);
        chk("abort_ptr0", 32'(bus.ptr), 32'd0);
        step("abort_w", 1'b0, 1'b1, 2'd2, 2'b11, 1'b1);
        chk("abort_y0", 32'(bus.y0), 32'd3);
        chk("abort_strobe", 32'(bus.y_strobe), 32'b0001);
        chk("abort_ptr", 32'(bus.ptr), 32'd1);
        chk("abort_fv", 32'(bus.frame_valid), 32'd0);

        // Clear beats a write at ptr=3
        step("clr_w1", 1'b0, 1'b1, 2'd0, 2'b10, 1'b1);
        step("clr_w2", 1'b0, 1'b1, 2'd0, 2'b11, 1'b1);
        chk("clr_pre_ptr", 32'(bus.ptr), 32'd3);
        step("clr_prio", 1'b1, 1'b1, 2'd0, 2'b11, 1'b1);
        chk("clr_frame", 32'(bus.frame), 32'd0);
        chk("clr_ptr", 32'(bus.ptr), 32'd0);
        chk("clr_fv", 32'(bus.frame_valid), 32'd0);

        // Asynchronous reset mid-frame, between edges
        step("ar_w0", 1'b0, 1'b1, 2'd0, 2'b11, 1'b1);
        step("ar_w1", 1'b0, 1'b1, 2'd0, 2'b10, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_frame", 32'(bus.frame), 32'd0);
        chk("ar_ptr", 32'(bus.ptr), 32'd0);
        chk("ar_strobe", 32'(bus.y_strobe), 32'd0);
        chk("ar_fv", 32'(bus.frame_valid), 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        step("ar_first", 1'b0, 1'b1, 2'd3, 2'b01, 1'b1);
        chk("ar_first_y0", 32'(bus.y0), 32'd1);
        chk("ar_first_strobe", 32'(bus.y_strobe), 32'b0001);

        // Random traffic against the reference
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
